ahb_slave_port_wrr_arbiter: RTL and testbench

Weighted round-robin arbiter for one slave port of the AHB-Lite matrix. It chooses which of four masters owns the slave's address phase and drives the one-hot address-in-progress vector that the slave stage uses to steer HADDR/HTRANS/HWRITE. Grants respect HMASTLOCK sequences and undefined-length bursts. Each master has a programmable weight: the number of consecutive transfers it may issue before the grant rotates.

---
 rtl/ahb_arb_pkg.sv | 28 ++
 rtl/ahb_slave_port_wrr_arbiter_if.sv | 22 ++
 rtl/ahb_rr_pick4.sv | 25 ++
 rtl/ahb_slave_port_wrr_arbiter.sv | 94 +++++++++
 tb/tb_ahb_slave_port_wrr_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared types, constants and weight unpack helper for the slave-port arbiter
package ahb_arb_pkg;

    localparam int NUM_M        = 4;
    localparam int MAX_WEIGHT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        LOCK = 2'd2
    } arb_state_e;

    localparam logic [NUM_M-1:0] MASTER_NONE = 4'b0000;
    localparam logic [NUM_M-1:0] M0          = 4'b0001;
    localparam logic [NUM_M-1:0] M1          = 4'b0010;
    localparam logic [NUM_M-1:0] M2          = 4'b0100;
    localparam logic [NUM_M-1:0] M3          = 4'b1000;

    // Weights are packed {W3,W2,W1,W0}, ww bits each; callers zero-extend to 32 bits.
    function automatic logic [MAX_WEIGHT_W-1:0] unpack_weight(
        input logic [4*MAX_WEIGHT_W-1:0] packed_w,
        input int                        idx,
        input int                        ww
    );
        return MAX_WEIGHT_W'(packed_w >> (idx * ww)) & MAX_WEIGHT_W'((32'd1 << ww) - 32'd1);
    endfunction

endpackage

// File: rtl/ahb_slave_port_wrr_arbiter_if.sv
// rtl/ahb_slave_port_wrr_arbiter_if.sv - request/grant bundle between the matrix and one slave-port arbiter
interface ahb_slave_port_wrr_arbiter_if import ahb_arb_pkg::*; ();

    logic [NUM_M-1:0] MADDRSEL;
    logic             ADDRPHEND;
    logic [NUM_M-1:0] MLOCK;
    logic [NUM_M-1:0] MBURST;
    logic [NUM_M-1:0] GRANT;
    logic             GRANT_VLD;
    logic             ARB_EVT;

    modport slave (
        input  MADDRSEL, ADDRPHEND, MLOCK, MBURST,
        output GRANT, GRANT_VLD, ARB_EVT
    );

    modport master (
        output MADDRSEL, ADDRPHEND, MLOCK, MBURST,
        input  GRANT, GRANT_VLD, ARB_EVT
    );

endinterface

// File: rtl/ahb_rr_pick4.sv
// rtl/ahb_rr_pick4.sv - rotating-priority encoder, searches ptr+1 .. ptr+4 (ptr itself last)
module ahb_rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk from the lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_port_wrr_arbiter.sv
// rtl/ahb_slave_port_wrr_arbiter.sv - weighted round-robin address-phase arbiter for one AHB-Lite slave port
module ahb_slave_port_wrr_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int                      WEIGHT_W    = 3,
    parameter logic [4*WEIGHT_W-1:0]   DEF_WEIGHTS = 12'h249
) (
    input  logic                       HCLK,
    input  logic                       aresetn,
    input  logic                       CFG_WE,
    input  logic [4*WEIGHT_W-1:0]      CFG_WEIGHTS,
    ahb_slave_port_wrr_arbiter_if.slave bus
);

    arb_state_e             state_q, state_d;
    logic [NUM_M-1:0]       grant_q, grant_d;
    logic [WEIGHT_W-1:0]    credit_q, credit_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [4*WEIGHT_W-1:0]  weights_q;
    logic                   evt_q, vld_q;

    logic                   pick_found;
    logic [1:0]             pick_idx;
    logic [WEIGHT_W-1:0]    raw_w, load_w;
    logic                   keep;

    ahb_rr_pick4 u_pick (
        .req   (bus.MADDRSEL),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Credit loads read the registered weights, so a same-edge CFG write takes effect next load.
    assign raw_w  = WEIGHT_W'(unpack_weight(32'(weights_q), int'(pick_idx), WEIGHT_W));
    assign load_w = (raw_w == '0) ? WEIGHT_W'(1) : raw_w;

    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            grant_q   <= MASTER_NONE;
            credit_q  <= '0;
            ptr_q     <= 2'd3;
            weights_q <= DEF_WEIGHTS;
            evt_q     <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            credit_q <= credit_d;
            ptr_q    <= ptr_d;
            evt_q    <= (grant_d != grant_q) && (grant_d != MASTER_NONE);
            vld_q    <= |grant_d;
            if (CFG_WE) begin
                weights_q <= CFG_WEIGHTS;
            end
        end
    end

    // ptr_q doubles as the current grantee index whenever the state is not IDLE.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        credit_d = credit_q;
        ptr_d    = ptr_q;
        keep     = (state_q != IDLE) && bus.MADDRSEL[ptr_q];
        if ((state_q == IDLE) || bus.ADDRPHEND) begin
            if (keep && bus.MLOCK[ptr_q]) begin
                state_d = LOCK;
            end else if (keep && bus.MBURST[ptr_q]) begin
                state_d = OWN;
            end else if (keep && (credit_q > WEIGHT_W'(1))) begin
                state_d  = OWN;
                credit_d = credit_q - WEIGHT_W'(1);
            end else if (pick_found) begin
                state_d  = OWN;
                grant_d  = M0 << pick_idx;
                ptr_d    = pick_idx;
                credit_d = load_w;
            end else begin
                state_d  = IDLE;
                grant_d  = MASTER_NONE;
                credit_d = '0;
            end
        end
    end

    always_comb begin
        bus.GRANT     = grant_q;
        bus.GRANT_VLD = vld_q;
        bus.ARB_EVT   = evt_q;
    end

endmodule

// File: tb/tb_ahb_slave_port_wrr_arbiter.sv
// tb/tb_ahb_slave_port_wrr_arbiter.sv - scoreboard bench with an ownership/credit reference model
module tb_ahb_slave_port_wrr_arbiter;

    logic        HCLK = 1'b0;
    logic        aresetn = 1'b0;
    logic        CFG_WE = 1'b0;
    logic [11:0] CFG_WEIGHTS = 12'h0;

    ahb_slave_port_wrr_arbiter_if bus ();

    ahb_slave_port_wrr_arbiter #(
        .WEIGHT_W    (3),
        .DEF_WEIGHTS (12'h249)
    ) dut (
        .HCLK        (HCLK),
        .aresetn     (aresetn),
        .CFG_WE      (CFG_WE),
        .CFG_WEIGHTS (CFG_WEIGHTS),
        .bus         (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int         cyc;
        logic [5:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    int   m_owner;
    int   m_left;
    int   m_last;
    int   m_w[4];

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got grant/vld/evt=%b required=%b", nm, cyc, got, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_last  = 3;
        for (int i = 0; i < 4; i++) m_w[i] = 1;
    endtask

    task automatic step(input logic [3:0] rq, input logic ap, input logic [3:0] lk,
                        input logic [3:0] bu, input logic we, input logic [11:0] cw);
        int   prev;
        int   nw;
        exp_t e;
        logic [3:0] g;
        @(negedge HCLK);
        bus.MADDRSEL  = rq;
        bus.ADDRPHEND = ap;
        bus.MLOCK     = lk;
        bus.MBURST    = bu;
        CFG_WE        = we;
        CFG_WEIGHTS   = cw;
        prev = m_owner;
        if (m_owner < 0 || ap) begin
            if (m_owner >= 0 && rq[m_owner] && (lk[m_owner] || bu[m_owner])) begin
                nw = m_owner;
            end else if (m_owner >= 0 && rq[m_owner] && m_left > 1) begin
                m_left = m_left - 1;
            end else begin
                nw = -1;
                for (int k = 1; k <= 4; k++)
                    if (nw < 0 && rq[(m_last + k) % 4]) nw = (m_last + k) % 4;
                if (nw >= 0) begin
                    m_last = nw;
                    m_left = (m_w[nw] == 0) ? 1 : m_w[nw];
                end else begin
                    m_left = 0;
                end
                m_owner = nw;
            end
        end
        if (we)
            for (int i = 0; i < 4; i++) m_w[i] = int'((cw >> (3 * i)) & 12'h7);
        g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        e.cyc = cyc + 1;
        e.v   = {g, (m_owner >= 0), (m_owner >= 0 && m_owner != prev)};
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_reset", {bus.GRANT, bus.GRANT_VLD, bus.ARB_EVT}, 6'b0);
        exp_q.delete();
        model_reset();
        bus.MADDRSEL  = 4'b0;
        bus.ADDRPHEND = 1'b0;
        bus.MLOCK     = 4'b0;
        bus.MBURST    = 4'b0;
        CFG_WE        = 1'b0;
        repeat (2) @(negedge HCLK);
        check("in_reset", {bus.GRANT, bus.GRANT_VLD, bus.ARB_EVT}, 6'b0);
        aresetn = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (aresetn && exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("cycle", {bus.GRANT, bus.GRANT_VLD, bus.ARB_EVT}, e.v);
            end
        end
    end

    initial begin
        bus.MADDRSEL  = 4'b0;
        bus.ADDRPHEND = 1'b0;
        bus.MLOCK     = 4'b0;
        bus.MBURST    = 4'b0;
        model_reset();

        do_reset();
        step(4'b0000, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);
        repeat (8) step(4'b0101, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);

        step(4'b0000, 1'b1, 4'b0, 4'b0, 1'b1, 12'h24B);
        repeat (12) step(4'b0011, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);

        repeat (2) step(4'b0010, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);
        repeat (5) step(4'b0011, 1'b1, 4'b0010, 4'b0, 1'b0, 12'h0);
        repeat (3) step(4'b0011, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);

        repeat (2) step(4'b0011, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);
        repeat (4) step(4'b0011, 1'b0, 4'b0, 4'b0, 1'b0, 12'h0);
        repeat (6) step(4'b0011, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);

        do_reset();
        step(4'b0000, 1'b1, 4'b0, 4'b0, 1'b1, 12'h24B);
        step(4'b0001, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);
        step(4'b0011, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);
        step(4'b0011, 1'b1, 4'b0, 4'b0, 1'b1, 12'h24D);
        repeat (12) step(4'b0011, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);

        repeat (3) step(4'b1000, 1'b1, 4'b1000, 4'b0, 1'b0, 12'h0);
        do_reset();
        repeat (4) step(4'b1111, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);

        for (int i = 0; i < 400; i++) begin
            step(4'($urandom),
                 ($urandom % 4) != 0,
                 (($urandom % 6) == 0) ? 4'($urandom) : 4'b0,
                 (($urandom % 5) == 0) ? 4'($urandom) : 4'b0,
                 ($urandom % 25) == 0,
                 12'($urandom));
        end

        step(4'b0000, 1'b1, 4'b0, 4'b0, 1'b0, 12'h0);
        repeat (3) @(negedge HCLK);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
